// File: rtl/pc_write_ctrl_if.sv
// Bus bundle between the PC write controller and its neighbours.
// It carries the hazard, debug and redirect inputs and the PC load outputs.
// The master modport is the environment that drives the controls.
// The slave modport is pc_write_ctrl itself.
interface pc_write_ctrl_if #(
    parameter int MSB   = 32,
    parameter int CNT_W = 32
);
    logic [MSB-1:0]   i_pc;
    logic             i_run_cmd;
    logic             i_step_cmd;
    logic             i_stop_cmd;
    logic             i_stall;
    logic             i_branch_taken;
    logic [MSB-1:0]   i_branch_target;
    logic             i_jump;
    logic [MSB-1:0]   i_jump_target;
    logic             i_halt_detected;
    logic [MSB-1:0]   o_next_pc;
    logic             o_write_pc;
    logic [1:0]       o_state;
    logic             o_halted;
    logic [CNT_W-1:0] o_fetch_count;
    logic             o_misaligned;

    modport master (
        output i_pc, i_run_cmd, i_step_cmd, i_stop_cmd, i_stall,
               i_branch_taken, i_branch_target, i_jump, i_jump_target,
               i_halt_detected,
        input  o_next_pc, o_write_pc, o_state, o_halted, o_fetch_count,
               o_misaligned
    );

    modport slave (
        input  i_pc, i_run_cmd, i_step_cmd, i_stop_cmd, i_stall,
               i_branch_taken, i_branch_target, i_jump, i_jump_target,
               i_halt_detected,
        output o_next_pc, o_write_pc, o_state, o_halted, o_fetch_count,
               o_misaligned
    );
endinterface

// File: rtl/pc_write_ctrl.sv
// Next-PC selection and PC write strobe, gated by the debug run/step/stop
// FSM, hazard stalls and HALT detection.
// Optional feature: define PC_MISALIGN_TRAP_EN to trap misaligned
// branch/jump targets. The trap word-aligns the target, sets a sticky flag
// and halts the core.
module pc_write_ctrl #(
    parameter int MSB   = 32,
    parameter int INC   = 4,
    parameter int CNT_W = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    pc_write_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    state_t           state;
    logic             halted;
    logic             misaligned;
    logic [CNT_W-1:0] fetch_count;

    logic [MSB-1:0]   target;
    logic             redirect;
    logic             target_bad;
    logic             adv;
    logic             trap;
    logic             halt_stop;

    // Target selection: a taken branch outranks a jump, which outranks the sequential PC.
    always_comb begin
        redirect = bus.i_branch_taken | bus.i_jump;
        if (bus.i_branch_taken)
            target = bus.i_branch_target;
        else if (bus.i_jump)
            target = bus.i_jump_target;
        else
            target = bus.i_pc + MSB'(INC);
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign target_bad    = redirect & (target[1:0] != 2'b00);
    assign bus.o_next_pc = target_bad ? {target[MSB-1:2], 2'b00} : target;
`else
    assign target_bad    = 1'b0;
    assign bus.o_next_pc = target;
`endif

    // A taken branch squashes the HALT seen in IF, so a halt only blocks the write without one.
    assign adv       = ((state == S_RUN) || (state == S_STEP)) & ~bus.i_stall
                       & ~bus.i_stop_cmd & (~bus.i_halt_detected | bus.i_branch_taken);
    assign trap      = adv & target_bad;
    assign halt_stop = bus.i_halt_detected & ~bus.i_branch_taken & ~bus.i_stall;

    assign bus.o_write_pc    = adv;
    assign bus.o_state       = state;
    assign bus.o_halted      = halted;
    assign bus.o_fetch_count = fetch_count;
    assign bus.o_misaligned  = misaligned;

    // Debug FSM with its registered status: state, halted flag, fetch counter, trap flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            halted      <= 1'b0;
            fetch_count <= '0;
            misaligned  <= 1'b0;
        end else begin
            if (adv && (fetch_count != {CNT_W{1'b1}}))
                fetch_count <= fetch_count + 1'b1;
            if (trap)
                misaligned <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.i_run_cmd)
                        state <= S_RUN;
                    else if (bus.i_step_cmd)
                        state <= S_STEP;
                end
                S_RUN: begin
                    if (bus.i_stop_cmd) begin
                        state <= S_IDLE;
                    end else if (halt_stop || trap) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end
                end
                S_STEP: begin
                    if (bus.i_stop_cmd) begin
                        state <= S_IDLE;
                    end else if (halt_stop || trap) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (adv) begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_write_ctrl.sv
// Randomized bench for pc_write_ctrl. It checks the DUT against a reference
// model in the bench, plus directed scenarios with fixed expected values.
module tb_pc_write_ctrl;
    localparam int MSB   = 32;
    localparam int CNT_W = 32;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_STEP = 2, ST_HALT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_write_ctrl_if #(.MSB(MSB), .CNT_W(CNT_W)) ifc ();

    pc_write_ctrl #(.MSB(MSB), .INC(4), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model status.
    int          m_state;
    logic [31:0] m_cnt;
    logic        m_mis;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr_pulses();
        ifc.i_run_cmd  = 1'b0;
        ifc.i_step_cmd = 1'b0;
        ifc.i_stop_cmd = 1'b0;
    endtask

    task automatic clr_all();
        clr_pulses();
        ifc.i_stall         = 1'b0;
        ifc.i_branch_taken  = 1'b0;
        ifc.i_jump          = 1'b0;
        ifc.i_halt_detected = 1'b0;
    endtask

    // Called right after a negedge with inputs already set. The task checks
    // the combinational outputs, advances the model, checks the registered
    // outputs after the edge, and returns at the next negedge.
    task automatic tick();
        logic [31:0] tgt, nx;
        bit running, redir, bad, wr, hstop;
        #1;
        running = (m_state == ST_RUN) || (m_state == ST_STEP);
        redir   = ifc.i_branch_taken || ifc.i_jump;
        if (ifc.i_branch_taken)  tgt = ifc.i_branch_target;
        else if (ifc.i_jump)     tgt = ifc.i_jump_target;
        else                     tgt = ifc.i_pc + 32'd4;
        bad = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        bad = redir && (tgt[1:0] != 2'b00);
`endif
        nx = bad ? (tgt & ~32'd3) : tgt;
        wr = running && !ifc.i_stall && !ifc.i_stop_cmd
             && (!ifc.i_halt_detected || ifc.i_branch_taken);
        check("write_pc", ifc.o_write_pc, wr);
        check("next_pc", ifc.o_next_pc, nx);

        if (wr && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (wr && bad) m_mis = 1'b1;
        hstop = ifc.i_halt_detected && !ifc.i_branch_taken && !ifc.i_stall;
        if (m_state == ST_IDLE) begin
            if (ifc.i_run_cmd)       m_state = ST_RUN;
            else if (ifc.i_step_cmd) m_state = ST_STEP;
        end else if (running) begin
            if (ifc.i_stop_cmd)                     m_state = ST_IDLE;
            else if (hstop || (wr && bad))          m_state = ST_HALT;
            else if (m_state == ST_STEP && wr)      m_state = ST_IDLE;
        end

        @(posedge clk);
        #1;
        check("state", ifc.o_state, m_state);
        check("halted", ifc.o_halted, m_state == ST_HALT);
        check("fetch_count", ifc.o_fetch_count, m_cnt);
        check("misaligned", ifc.o_misaligned, m_mis);
        @(negedge clk);
        clr_pulses();
    endtask

    // Asynchronous reset. The inputs are left as they were, so a DUT that
    // was running must drop its write strobe before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_write_pc", ifc.o_write_pc, 1'b0);
        check("rst_state", ifc.o_state, 2'b00);
        check("rst_halted", ifc.o_halted, 1'b0);
        check("rst_count", ifc.o_fetch_count, 32'd0);
        check("rst_misaligned", ifc.o_misaligned, 1'b0);
        m_state = ST_IDLE;
        m_cnt   = '0;
        m_mis   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] saved_cnt;
        ifc.i_pc            = 32'h40;
        ifc.i_branch_target = '0;
        ifc.i_jump_target   = '0;
        clr_all();
        do_reset();

        // Run, then advance sequentially, then stop.
        ifc.i_run_cmd = 1'b1;
        tick();
        check("run_state", ifc.o_state, 2'b01);
        #1;
        check("run_first_write", ifc.o_write_pc, 1'b1);
        check("run_first_next", ifc.o_next_pc, 32'h44);
        tick();
        for (int i = 1; i < 4; i++) begin
            ifc.i_pc = 32'h40 + 32'(4 * i);
            tick();
        end
        ifc.i_stop_cmd = 1'b1;
        #1;
        check("stop_write", ifc.o_write_pc, 1'b0);
        tick();
        check("stop_state", ifc.o_state, 2'b00);
        check("run_count", ifc.o_fetch_count, 32'd4);

        // Branch outranks jump; sequential wrap at the top of the address space.
        ifc.i_run_cmd = 1'b1;
        tick();
        ifc.i_branch_taken = 1'b1; ifc.i_branch_target = 32'h100;
        ifc.i_jump         = 1'b1; ifc.i_jump_target   = 32'h200;
        #1;
        check("branch_prio", ifc.o_next_pc, 32'h100);
        tick();
        clr_all();
        ifc.i_pc = 32'hFFFF_FFFC;
        #1;
        check("pc_wrap", ifc.o_next_pc, 32'h0);
        tick();
        ifc.i_stop_cmd = 1'b1;
        tick();

        // Single step held off by a stall.
        saved_cnt = m_cnt;
        ifc.i_pc = 32'h80;
        ifc.i_step_cmd = 1'b1; ifc.i_stall = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        check("step_held", ifc.o_state, 2'b10);
        ifc.i_stall = 1'b0;
        #1;
        check("step_write", ifc.o_write_pc, 1'b1);
        tick();
        check("step_done", ifc.o_state, 2'b00);
        check("step_count", ifc.o_fetch_count, saved_cnt + 32'd1);

        // Halt overridden by a taken branch, then a real halt.
        ifc.i_run_cmd = 1'b1;
        tick();
        ifc.i_halt_detected = 1'b1;
        ifc.i_branch_taken = 1'b1; ifc.i_branch_target = 32'h300;
        #1;
        check("halt_branch_write", ifc.o_write_pc, 1'b1);
        tick();
        check("halt_branch_state", ifc.o_state, 2'b01);
        ifc.i_branch_taken = 1'b0;
        #1;
        check("halt_write", ifc.o_write_pc, 1'b0);
        tick();
        check("halt_state", ifc.o_state, 2'b11);
        check("halted_flag", ifc.o_halted, 1'b1);
        ifc.i_halt_detected = 1'b0;
        ifc.i_run_cmd = 1'b1;
        tick();
        ifc.i_step_cmd = 1'b1;
        tick();
        check("halt_sticky", ifc.o_state, 2'b11);

        // Misaligned jump target.
        do_reset();
        ifc.i_run_cmd = 1'b1;
        tick();
        ifc.i_jump = 1'b1; ifc.i_jump_target = 32'h102;
        #1;
`ifdef PC_MISALIGN_TRAP_EN
        check("misalign_next", ifc.o_next_pc, 32'h100);
`else
        check("misalign_next", ifc.o_next_pc, 32'h102);
`endif
        tick();
`ifdef PC_MISALIGN_TRAP_EN
        check("misalign_flag", ifc.o_misaligned, 1'b1);
        check("misalign_state", ifc.o_state, 2'b11);
`else
        check("misalign_flag", ifc.o_misaligned, 1'b0);
        check("misalign_state", ifc.o_state, 2'b01);
`endif
        clr_all();
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                ifc.i_run_cmd       = ($urandom_range(0, 7) == 0);
                ifc.i_step_cmd      = ($urandom_range(0, 7) == 0);
                ifc.i_stop_cmd      = ($urandom_range(0, 11) == 0);
                ifc.i_stall         = ($urandom_range(0, 3) == 0);
                ifc.i_branch_taken  = ($urandom_range(0, 5) == 0);
                ifc.i_jump          = ($urandom_range(0, 5) == 0);
                ifc.i_halt_detected = ($urandom_range(0, 24) == 0);
                ifc.i_pc            = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                                                   : ($urandom() & ~32'd3);
                ifc.i_branch_target = $urandom() & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : ~32'd3);
                ifc.i_jump_target   = $urandom() & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : ~32'd3);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
